mdlu_sequencer: RTL

Multi-cycle controller for the multiply/divide unit (MDLU) of the single-cycle MIPS core. It accepts one MDLU command from the decode/ALU control path, performs the signed multiply (shift-add) or signed divide (restoring) one bit per cycle, and holds the HI/LO result registers. It raises a stall to the core when an MFHI/MFLO or a new command arrives while an operation is in flight.

---
 rtl/mdlu_sequencer_pkg.sv | 32 +++
 rtl/mdlu_div_step.sv | 32 +++
 rtl/mdlu_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mdlu_sequencer_pkg.sv
// Shared definitions for the multiply/divide unit sequencer.
//   MDLU_OP_W    : width of the MDLU op code
//   mdlu_op_t    : op code encoding (MULT, DIV, ZERO, illegal)
//   mdlu_state_t : sequencer states
//   ITER_W       : iteration counter width for the default 32-bit datapath
//   iter_w()     : counter width for an arbitrary operand width
package libMdlu;

  localparam int unsigned MDLU_OP_W  = 2;
  localparam int unsigned MDLU_WIDTH = 32;

  typedef enum logic [MDLU_OP_W-1:0] {
    MDLU_MULT    = 2'd0,
    MDLU_DIV     = 2'd1,
    MDLU_ZERO    = 2'd2,
    MDLU_ILLEGAL = 2'd3
  } mdlu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    FIX
  } mdlu_state_t;

  function automatic int unsigned iter_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  localparam int unsigned ITER_W = $clog2(MDLU_WIDTH) + 1;

endpackage

// File: rtl/mdlu_div_step.sv
// One restoring-divide iteration, purely combinational.
//   rem_i  : partial remainder (always < divisor)
//   quo_i  : quotient/dividend shift register; MSB is the next dividend bit
//   dvsr_i : divisor magnitude
//   rem_o  : updated partial remainder
//   quo_o  : shift register with the new quotient bit in the LSB
module mdlu_div_step
  import libMdlu::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  // One spare MSB so the trial subtraction exposes its borrow.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {2'b00, dvsr_i};
    borrow  = diff[WIDTH+1];
    rem_o   = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
    quo_o   = {quo_i[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/mdlu_sequencer.sv
// Multi-cycle multiply/divide controller with HI/LO result registers.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start, op    : command request (accepted only in IDLE) and op code
//   operand_a/b  : rs / rt values, two's complement
//   mf_req       : core is executing MFHI/MFLO this cycle
//   busy         : operation in flight
//   stall        : busy & (mf_req | start), combinational
//   done         : one-cycle pulse when hi/lo carry a new result
//   div_by_zero  : last DIV had a zero divisor; cleared on next accepted start
//   hi, lo       : result registers
module mdlu_sequencer
  import libMdlu::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MDLU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  input  logic                 mf_req,
  output logic                 busy,
  output logic                 stall,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo
);

  localparam int unsigned CNT_W = iter_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mdlu_state_t        state_q, state_d;
  mdlu_op_t           op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // MULT: {partial product, multiplier}. DIV: lower half is the quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  // |a| for MULT (multiplicand), |b| for DIV (divisor).
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic               neg_q, neg_d;
  logic               sgn_a_q, sgn_a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  mdlu_op_t           op_in;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH-1:0]   div_quo;

  assign op_in = mdlu_op_t'(op);
  assign abs_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign abs_b = operand_b[WIDTH-1] ? -operand_b : operand_b;

  mdlu_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i  (rem_q),
    .quo_i  (acc_q[WIDTH-1:0]),
    .dvsr_i (mag_q),
    .rem_o  (div_rem),
    .quo_o  (div_quo)
  );

  // Shift-add: conditionally add the multiplicand to the upper half, then
  // shift the whole accumulator right; the carry drops into the MSB.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Sign fix-up. The -2^(W-1) / -1 case falls out naturally: the quotient
  // magnitude 2^(W-1) is left un-negated and reads back as 0x80..0.
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sgn_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    sgn_a_d = sgn_a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (op_in)
            MDLU_MULT: begin
              op_d    = MDLU_MULT;
              mag_d   = abs_a;
              acc_d   = {{WIDTH{1'b0}}, abs_b};
              neg_d   = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
              sgn_a_d = operand_a[WIDTH-1];
              cnt_d   = '0;
              dbz_d   = 1'b0;
              state_d = MULT;
            end
            MDLU_DIV: begin
              if (operand_b == '0) begin
                hi_d   = operand_a;
                lo_d   = '1;
                dbz_d  = 1'b1;
                done_d = 1'b1;
              end else begin
                op_d    = MDLU_DIV;
                mag_d   = abs_b;
                acc_d   = {{WIDTH{1'b0}}, abs_a};
                rem_d   = '0;
                neg_d   = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                sgn_a_d = operand_a[WIDTH-1];
                cnt_d   = '0;
                dbz_d   = 1'b0;
                state_d = DIV;
              end
            end
            MDLU_ZERO: begin
              hi_d   = '0;
              lo_d   = '0;
              dbz_d  = 1'b0;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MULT: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      DIV: begin
        acc_d = {acc_q[2*WIDTH-1:WIDTH], div_quo};
        rem_d = div_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      FIX: begin
        if (op_q == MDLU_DIV) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= MDLU_MULT;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      sgn_a_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      sgn_a_q <= sgn_a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign stall       = busy & (mf_req | start);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
